// File: rtl/c3aibadapt_sr_defs_pkg.sv
// Shared definitions for the sideband shift-register transmit path:
// FSM encodings and the counter width helper.
package c3aibadapt_sr_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } sr_state_t;

    localparam int unsigned GAP_CNT_W = 4;

    // Bits needed to hold n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/c3aibadapt_sr_tx_cnt.sv
// Loadable down-counter with enable; stops at zero and flags it.
module c3aibadapt_sr_tx_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/c3aibadapt_sr_tx_ctrl.sv
// Sideband shift-register transmit controller: takes a word over valid/ready,
// strobes the far-end load, then shifts the word out MSB-first on sr_en.
module c3aibadapt_sr_tx_ctrl
    import c3aibadapt_sr_defs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic        IDLE_VAL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  sr_en,
    output logic                  sr_load,
    output logic                  sr_dataout,
    output logic                  sr_frame,
    output logic                  tx_done
);

    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned CNT_W    = cnt_width(DATA_WIDTH);
    localparam int unsigned GAP_LOAD = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    sr_state_t     state, state_nxt;
    logic [DW-1:0] shreg, shreg_nxt, shreg_shl;
    logic          bit_load_c, bit_dec_c, bit_zero_c;
    logic          gap_load_c, gap_dec_c, gap_zero_c;
    logic          ready_nxt, load_nxt, frame_nxt, done_nxt, dout_nxt;

    c3aibadapt_sr_tx_cnt #(.WIDTH(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load_c),
        .load_val (CNT_W'(DATA_WIDTH - 1)),
        .en       (bit_dec_c),
        .zero_c   (bit_zero_c)
    );

    c3aibadapt_sr_tx_cnt #(.WIDTH(GAP_CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load_c),
        .load_val (GAP_CNT_W'(GAP_LOAD)),
        .en       (gap_dec_c),
        .zero_c   (gap_zero_c)
    );

    // Truncating the concatenation also covers the single-bit frame.
    assign shreg_shl = DW'({shreg, IDLE_VAL});

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bit_load_c = 1'b0;
        bit_dec_c  = 1'b0;
        gap_load_c = 1'b0;
        gap_dec_c  = 1'b0;
        ready_nxt  = 1'b0;
        load_nxt   = 1'b0;
        frame_nxt  = 1'b0;
        done_nxt   = 1'b0;
        dout_nxt   = IDLE_VAL;
        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_nxt  = ST_LOAD;
                    shreg_nxt  = tx_data;
                    bit_load_c = 1'b1;
                    load_nxt   = 1'b1;
                    frame_nxt  = 1'b1;
                    dout_nxt   = tx_data[DW-1];
                end else begin
                    ready_nxt  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
                frame_nxt = 1'b1;
                dout_nxt  = shreg[DW-1];
            end
            ST_SHIFT: begin
                frame_nxt = 1'b1;
                dout_nxt  = shreg[DW-1];
                if (sr_en) begin
                    shreg_nxt = shreg_shl;
                    bit_dec_c = 1'b1;
                    dout_nxt  = shreg_shl[DW-1];
                    // Last bit consumed: close the frame.
                    if (bit_zero_c) begin
                        done_nxt  = 1'b1;
                        frame_nxt = 1'b0;
                        dout_nxt  = IDLE_VAL;
                        if (GAP_CYCLES == 0) begin
                            state_nxt = ST_IDLE;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt  = ST_GAP;
                            gap_load_c = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_zero_c) begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                end else begin
                    gap_dec_c = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            tx_ready   <= 1'b0;
            sr_load    <= 1'b0;
            sr_frame   <= 1'b0;
            tx_done    <= 1'b0;
            sr_dataout <= IDLE_VAL;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            tx_ready   <= ready_nxt;
            sr_load    <= load_nxt;
            sr_frame   <= frame_nxt;
            tx_done    <= done_nxt;
            sr_dataout <= dout_nxt;
        end
    end

endmodule
